// File: rtl/card_pkg.sv
// ============================================================================
// Module  : card_pkg
// Brief   : Shared sizes, colour type and loader state encoding for the card
//           sprite controller. Optional feature macro: CARD_MIRROR_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package card_pkg;

    localparam int CARD_W  = 16;
    localparam int CARD_H  = 32;
    localparam int ADDR_W  = 9;
    localparam int COLOR_W = 3;

    typedef logic [COLOR_W-1:0] color_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2,
        HOLD  = 2'd3
    } ld_state_t;

endpackage

`default_nettype wire

// File: rtl/card_window.sv
// ============================================================================
// Module  : card_window
// Brief   : Combinational card-window hit test and sprite RAM read address.
//           CARD_MIRROR_EN adds card_flip for a 180-degree rotated card.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module card_window #(
    parameter int CARD_W = card_pkg::CARD_W,
    parameter int CARD_H = card_pkg::CARD_H
) (
    input  logic [8:0]                  hcount,
    input  logic [7:0]                  vcount,
    input  logic                        active,
    input  logic [7:0]                  card_x,
    input  logic [7:0]                  card_y,
    input  logic                        card_show,
`ifdef CARD_MIRROR_EN
    input  logic                        card_flip,
`endif
    output logic                        in_win,
    output logic [card_pkg::ADDR_W-1:0] raddr
);

    import card_pkg::*;

    localparam int XW = $clog2(CARD_W);
    localparam int YW = $clog2(CARD_H);

    logic [9:0]    w_dx;
    logic [9:0]    w_dy;
    logic [XW-1:0] w_col;
    logic [YW-1:0] w_row;

    // Ten-bit differences: a card origin right of / below the beam wraps to a
    // large value and therefore fails the range test instead of aliasing.
    assign w_dx = {1'b0, hcount} - {2'b00, card_x};
    assign w_dy = {2'b00, vcount} - {2'b00, card_y};

    assign in_win = active & card_show
                  & (w_dx < 10'(CARD_W))
                  & (w_dy < 10'(CARD_H));

`ifdef CARD_MIRROR_EN
    // Both dimensions are powers of two, so SIZE-1-d is the bitwise inverse.
    assign w_col = card_flip ? ~w_dx[XW-1:0] : w_dx[XW-1:0];
    assign w_row = card_flip ? ~w_dy[YW-1:0] : w_dy[YW-1:0];
`else
    assign w_col = w_dx[XW-1:0];
    assign w_row = w_dy[YW-1:0];
`endif

    assign raddr = {w_row, w_col};

endmodule

`default_nettype wire

// File: rtl/card_sprite_ctrl.sv
// ============================================================================
// Module  : card_sprite_ctrl
// Brief   : Card sprite RAM controller: per-pixel fetch for the VGA beam plus
//           a req/ack loader write port. Optional macro: CARD_MIRROR_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module card_sprite_ctrl #(
    parameter int         CARD_W = card_pkg::CARD_W,
    parameter int         CARD_H = card_pkg::CARD_H,
    parameter logic [2:0] TRANSP = 3'b000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [8:0]                   hcount,
    input  logic [7:0]                   vcount,
    input  logic                         active,
    input  logic [7:0]                   card_x,
    input  logic [7:0]                   card_y,
    input  logic                         card_show,
`ifdef CARD_MIRROR_EN
    input  logic                         card_flip,
`endif
    input  logic                         ld_req,
    input  logic [card_pkg::ADDR_W-1:0]  ld_addr,
    input  logic [card_pkg::COLOR_W-1:0] ld_data,
    output logic                         ld_ack,
    output logic                         mem_we,
    output logic                         mem_re,
    output logic [card_pkg::ADDR_W-1:0]  mem_waddr,
    output logic [card_pkg::ADDR_W-1:0]  mem_raddr,
    output logic [card_pkg::COLOR_W-1:0] mem_wdata,
    input  logic [card_pkg::COLOR_W-1:0] mem_rdata,
    output logic                         pix_hit,
    output logic [card_pkg::COLOR_W-1:0] pix_color
);

    import card_pkg::*;

    ld_state_t         r_state;
    ld_state_t         w_next_state;
    logic              w_in_win;
    logic [ADDR_W-1:0] w_raddr;
    logic [ADDR_W-1:0] r_waddr;
    color_t            r_wdata;
    logic              r_hit_d;
    logic              w_ld_accept;

    card_window #(
        .CARD_W    (CARD_W),
        .CARD_H    (CARD_H)
    ) u_window (
        .hcount    (hcount),
        .vcount    (vcount),
        .active    (active),
        .card_x    (card_x),
        .card_y    (card_y),
        .card_show (card_show),
`ifdef CARD_MIRROR_EN
        .card_flip (card_flip),
`endif
        .in_win    (w_in_win),
        .raddr     (w_raddr)
    );

    // The beam fetch owns the RAM: a write may only start while the window is shut.
    assign w_ld_accept = (r_state == IDLE) && ld_req && !w_in_win;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_ld_accept) w_next_state = WRITE;
            WRITE:   w_next_state = ACK;
            ACK:     w_next_state = HOLD;
            HOLD:    if (!ld_req) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_we = 1'b0;
        ld_ack = 1'b0;
        case (r_state)
            WRITE:   mem_we = 1'b1;
            ACK:     ld_ack = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_ld_accept) begin
            r_waddr <= ld_addr;
            r_wdata <= ld_data;
        end
    end

    // Tracks the RAM's one-cycle read latency so hit lines up with mem_rdata.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hit_d <= 1'b0;
        end else begin
            r_hit_d <= w_in_win;
        end
    end

    assign mem_re    = w_in_win;
    assign mem_raddr = w_raddr;
    assign mem_waddr = r_waddr;
    assign mem_wdata = r_wdata;

    assign pix_hit   = r_hit_d && (mem_rdata != TRANSP);
    assign pix_color = pix_hit ? mem_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_card_sprite_ctrl.sv
// ============================================================================
// Module  : tb_card_sprite_ctrl
// Brief   : Self-checking bench for card_sprite_ctrl with a sprite RAM model
//           and a window/loader reference model. Honours CARD_MIRROR_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_card_sprite_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [8:0] hcount;
    logic [7:0] vcount;
    logic       active;
    logic [7:0] card_x;
    logic [7:0] card_y;
    logic       card_show;
`ifdef CARD_MIRROR_EN
    logic       card_flip;
`endif
    logic       ld_req;
    logic [8:0] ld_addr;
    logic [2:0] ld_data;
    logic       ld_ack;
    logic       mem_we;
    logic       mem_re;
    logic [8:0] mem_waddr;
    logic [8:0] mem_raddr;
    logic [2:0] mem_wdata;
    logic [2:0] mem_rdata;
    logic       pix_hit;
    logic [2:0] pix_color;

    int n_checks = 0;
    int n_errors = 0;
    int cnt_re   = 0;
    int cnt_hit  = 0;

    logic [2:0] env_ram [0:511];
    logic [2:0] ref_mem [0:511];
    logic [2:0] img     [0:511];
    logic       fill;

    always #5 clock = ~clock;

    card_sprite_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .hcount    (hcount),
        .vcount    (vcount),
        .active    (active),
        .card_x    (card_x),
        .card_y    (card_y),
        .card_show (card_show),
`ifdef CARD_MIRROR_EN
        .card_flip (card_flip),
`endif
        .ld_req    (ld_req),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_ack    (ld_ack),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_waddr (mem_waddr),
        .mem_raddr (mem_raddr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .pix_hit   (pix_hit),
        .pix_color (pix_color)
    );

    // Sprite RAM: registered read, read-before-write on a shared address.
    always @(posedge clock) begin
        if (mem_we) env_ram[mem_waddr] <= mem_wdata;
        if (mem_re) mem_rdata <= env_ram[mem_raddr];
        if (fill) begin
            for (int i = 0; i < 512; i++) env_ram[i] <= img[i];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit in_card(int h, int v, int cx, int cy, bit act, bit show);
        int dx;
        int dy;
        dx = h - cx;
        dy = v - cy;
        return act && show && dx >= 0 && dx < 16 && dy >= 0 && dy < 32;
    endfunction

    // Row-major sprite index; the rotated card reads the image back to front.
    function automatic int card_addr(int h, int v, int cx, int cy, bit flip);
        int lin;
        lin = (v - cy) * 16 + (h - cx);
        return flip ? 511 - lin : lin;
    endfunction

    // Reference state about the previous cycle.
    bit         p_reset = 1'b1;
    bit         p_req   = 1'b0;
    bit         p_in    = 1'b0;
    bit         p_we    = 1'b0;
    bit         p_ack   = 1'b0;
    bit         p_hold  = 1'b0;
    bit         p_idle  = 1'b1;
    bit         p_hit   = 1'b0;
    logic [2:0] p_col   = 3'b000;
    logic [8:0] p_laddr = 9'd0;
    logic [2:0] p_ldata = 3'd0;

    always @(negedge clock) begin : monitor
        int   a;
        bit   m_in;
        bit   flip;
        bit   e_we;
        bit   e_ack;
        bit   n_hold;
        bit   n_idle;
        if (fill) begin
            for (int i = 0; i < 512; i++) ref_mem[i] = img[i];
        end
`ifdef CARD_MIRROR_EN
        flip = card_flip;
`else
        flip = 1'b0;
`endif
        m_in = in_card(int'(hcount), int'(vcount), int'(card_x), int'(card_y), active, card_show);
        a    = m_in ? card_addr(int'(hcount), int'(vcount), int'(card_x), int'(card_y), flip) : 0;
        check_val("mem_re", 32'(mem_re), 32'(m_in));
        if (m_in) check_val("mem_raddr", 32'(mem_raddr), 32'(a));

        if (p_reset) begin
            check_val("pix_hit_rst", 32'(pix_hit), 32'd0);
            check_val("pix_color_rst", 32'(pix_color), 32'd0);
        end else begin
            check_val("pix_hit", 32'(pix_hit), 32'(p_hit));
            check_val("pix_color", 32'(pix_color), 32'(p_col));
        end
        cnt_re  += int'(mem_re);
        cnt_hit += int'(pix_hit);

        // A request may start a write only from a ready loader and a shut window.
        e_we  = !p_reset && p_idle && p_req && !p_in;
        e_ack = !p_reset && p_we;
        check_val("mem_we", 32'(mem_we), 32'(e_we));
        check_val("ld_ack", 32'(ld_ack), 32'(e_ack));
        if (e_we) begin
            check_val("mem_waddr", 32'(mem_waddr), 32'(p_laddr));
            check_val("mem_wdata", 32'(mem_wdata), 32'(p_ldata));
        end

        p_hit = m_in && (ref_mem[a] != 3'b000);
        p_col = p_hit ? ref_mem[a] : 3'b000;
        if (e_we) ref_mem[p_laddr] = p_ldata;

        // After an ack the loader only re-arms once the request has been seen low.
        n_hold = !p_reset && (p_ack || (p_hold && p_req));
        n_idle = p_reset || (p_idle && !e_we) || (p_hold && !p_req);

        p_reset = reset;
        p_req   = ld_req;
        p_in    = m_in;
        p_laddr = ld_addr;
        p_ldata = ld_data;
        p_we    = e_we;
        p_ack   = e_ack;
        p_hold  = n_hold;
        p_idle  = n_idle;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_image();
        fill = 1'b1;
        tick();
        fill = 1'b0;
    endtask

    initial begin : driver
        int base_re;
        int base_hit;
        int hold_left;
        int t;

        reset = 1'b1;  hcount = '0;  vcount = '0;  active = 1'b0;
        card_x = '0;   card_y = '0;  card_show = 1'b0;
        ld_req = 1'b0; ld_addr = '0; ld_data = '0; fill = 1'b0;
`ifdef CARD_MIRROR_EN
        card_flip = 1'b0;
`endif
        for (int i = 0; i < 512; i++) img[i] = 3'b101;
        repeat (3) tick();
        check_val("rst_ld_ack", 32'(ld_ack), 32'd0);
        check_val("rst_mem_we", 32'(mem_we), 32'd0);
        check_val("rst_mem_re", 32'(mem_re), 32'd0);
        check_val("rst_waddr", 32'(mem_waddr), 32'd0);
        check_val("rst_wdata", 32'(mem_wdata), 32'd0);
        check_val("rst_pix_hit", 32'(pix_hit), 32'd0);
        check_val("rst_pix_color", 32'(pix_color), 32'd0);
        reset = 1'b0;
        load_image();

        // Horizontal sweep across a card at (100,50).
        card_x = 8'd100; card_y = 8'd50; vcount = 8'd60;
        active = 1'b1;   card_show = 1'b1;
        base_re  = cnt_re;
        base_hit = cnt_hit;
        for (int h = 95; h <= 120; h++) begin
            hcount = 9'(h);
            tick();
        end
        active = 1'b0;
        tick();
        tick();
        check_val("sweep_re_count", 32'(cnt_re - base_re), 32'd16);
        check_val("sweep_hit_count", 32'(cnt_hit - base_hit), 32'd16);

        // Transparent entry at address 50, pixel (2,3) of a card at the origin.
        img[50] = 3'b000;
        load_image();
        card_x = 8'd0; card_y = 8'd0; hcount = 9'd2; vcount = 8'd3; active = 1'b1;
        @(negedge clock);
        check_val("transp_raddr", 32'(mem_raddr), 32'd50);
        tick();
        check_val("transp_pix_hit", 32'(pix_hit), 32'd0);
        active = 1'b0;
        tick();

        // Loader write with the window shut, then read it back.
        ld_req = 1'b1; ld_addr = 9'd7; ld_data = 3'b011;
        tick();
        check_val("ld_we", 32'(mem_we), 32'd1);
        check_val("ld_waddr", 32'(mem_waddr), 32'd7);
        check_val("ld_wdata", 32'(mem_wdata), 32'd3);
        check_val("ld_ack_early", 32'(ld_ack), 32'd0);
        tick();
        check_val("ld_ack", 32'(ld_ack), 32'd1);
        check_val("ld_we_once", 32'(mem_we), 32'd0);
        ld_req = 1'b0;
        tick();
        tick();
        hcount = 9'd7; vcount = 8'd0; active = 1'b1;
        tick();
        check_val("rb7_hit", 32'(pix_hit), 32'd1);
        check_val("rb7_color", 32'(pix_color), 32'd3);
        active = 1'b0;
        tick();

        // Request held during ten in-window cycles, then held past its ack.
        active = 1'b1; vcount = 8'd0;
        ld_req = 1'b1; ld_addr = 9'd33; ld_data = 3'd6;
        for (int i = 0; i < 10; i++) begin
            hcount = 9'(i);
            tick();
            check_val("we_blocked", 32'(mem_we), 32'd0);
        end
        hcount = 9'd200;
        tick();
        check_val("we_after_win", 32'(mem_we), 32'd1);
        check_val("we_after_addr", 32'(mem_waddr), 32'd33);
        tick();
        check_val("ack_after_win", 32'(ld_ack), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("we_held", 32'(mem_we), 32'd0);
        end
        ld_req = 1'b0;
        tick();
        hcount = 9'd1; vcount = 8'd2;
        tick();
        check_val("rb33_color", 32'(pix_color), 32'd6);
        active = 1'b0;
        tick();

        // Reset landing on the WRITE cycle while the window opens.
        ld_req = 1'b1; ld_addr = 9'd100; ld_data = 3'd2;
        tick();
        check_val("wr_before_rst", 32'(mem_we), 32'd1);
        reset = 1'b1; ld_req = 1'b0;
        hcount = 9'd0; vcount = 8'd0; active = 1'b1;
        tick();
        check_val("rst_wr_we", 32'(mem_we), 32'd0);
        check_val("rst_wr_ack", 32'(ld_ack), 32'd0);
        check_val("rst_wr_hit", 32'(pix_hit), 32'd0);
        reset = 1'b0; active = 1'b0;
        tick();
        check_val("rst_wr_idle", 32'(mem_we), 32'd0);

`ifdef CARD_MIRROR_EN
        card_x = 8'd0; card_y = 8'd0; hcount = 9'd0; vcount = 8'd0;
        active = 1'b1; card_flip = 1'b1;
        @(negedge clock);
        check_val("flip_raddr", 32'(mem_raddr), 32'd511);
        tick();
        active = 1'b0; card_flip = 1'b0;
        tick();
`endif

        // Randomised beam positions, window changes, loader traffic and resets.
        for (int i = 0; i < 512; i++) img[i] = 3'($urandom_range(0, 7));
        load_image();
        hold_left = -1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                card_x = 8'($urandom_range(0, 255));
                card_y = 8'($urandom_range(0, 255));
            end
            hcount    = 9'(int'(card_x) + int'($urandom_range(0, 21)) - 2);
            vcount    = 8'(int'(card_y) + int'($urandom_range(0, 35)) - 2);
            active    = ($urandom_range(0, 9) != 0);
            card_show = ($urandom_range(0, 9) != 0);
`ifdef CARD_MIRROR_EN
            card_flip = 1'($urandom_range(0, 1));
`endif
            reset = ($urandom_range(0, 79) == 0);
            if (reset) begin
                ld_req    = 1'b0;
                hold_left = -1;
            end else if (!ld_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    ld_req  = 1'b1;
                    ld_addr = 9'($urandom_range(0, 511));
                    ld_data = 3'($urandom_range(0, 7));
                end
            end else if (hold_left > 0) begin
                hold_left--;
            end else if (hold_left == 0) begin
                ld_req    = 1'b0;
                hold_left = -1;
            end
            tick();
            if (ld_ack && ld_req && hold_left < 0) hold_left = int'($urandom_range(0, 2));
        end

        // A lone request in a quiet frame must still be acknowledged in time.
        reset = 1'b0; active = 1'b0; ld_req = 1'b0;
        repeat (3) tick();
        ld_req = 1'b1; ld_addr = 9'd511; ld_data = 3'd4;
        t = 0;
        do begin
            tick();
            t++;
        end while (!ld_ack && t < 40);
        if (!ld_ack) check_val("ack_timeout", 32'(ld_ack), 32'd1);
        ld_req = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
